// File: rtl/fmc_i2c_init_sequencer_if.sv
// Byte-level command/response channel between the FMC init sequencer
// and the I2C byte master.
interface fmc_i2c_init_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_byte;
  logic       cmd_start;
  logic       cmd_stop;
  logic       rsp_valid;
  logic       rsp_nack;

  modport master (
    output cmd_valid,
    output cmd_byte,
    output cmd_start,
    output cmd_stop,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_byte,
    input  cmd_start,
    input  cmd_stop,
    output cmd_ready,
    output rsp_valid,
    output rsp_nack
  );
endinterface

// File: rtl/fmc_i2c_init_sequencer.sv
// Walks a table of I2C register writes after power-up, one
// addr/reg/data transaction per entry, with NACK retries and bus gaps.
module fmc_i2c_init_sequencer #(
  parameter int NUM_ENTRIES = 8,
  parameter int MAX_RETRIES = 3,
  parameter int GAP_CYCLES  = 500,
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  output logic [IW-1:0]           o_tbl_idx,
  input  logic [22:0]             i_tbl_entry,
  fmc_i2c_init_sequencer_if.master i2c,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [IW-1:0]           o_err_idx
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR   = 4'd1;
  localparam logic [3:0] S_WAIT_A = 4'd2;
  localparam logic [3:0] S_REG    = 4'd3;
  localparam logic [3:0] S_WAIT_R = 4'd4;
  localparam logic [3:0] S_DATA   = 4'd5;
  localparam logic [3:0] S_WAIT_D = 4'd6;
  localparam logic [3:0] S_GAP    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERROR  = 4'd9;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_ENTRIES - 1);
  localparam logic [GW-1:0] GAP_LOAD  =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]    RETRY_MAX = 5'(MAX_RETRIES);
  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

  logic [3:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [3:0]    r_retry;
  logic [GW-1:0] r_gap;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic [IW-1:0] r_err_idx;
  logic          r_cmd_valid;
  logic [7:0]    r_cmd_byte;
  logic          r_cmd_start;
  logic          r_cmd_stop;

  logic          w_idle_like;
  logic          w_start_ok;
  logic          w_wait;
  logic          w_ack;
  logic          w_nack;
  logic          w_hs;
  logic          w_last;
  logic          w_eoe;
  logic          w_retry_end;
  logic          w_to_gap;
  logic          w_gap_done;
  logic          w_load_addr;
  logic          w_load_reg;
  logic          w_load_data;
  logic [IW-1:0] w_idx_nxt;

  assign w_idle_like = (r_state == S_IDLE) |
                       (r_state == S_DONE) |
                       (r_state == S_ERROR);
  assign w_start_ok  = i_start & w_idle_like;
  assign w_wait      = (r_state == S_WAIT_A) |
                       (r_state == S_WAIT_R) |
                       (r_state == S_WAIT_D);
  assign w_ack       = w_wait & i2c.rsp_valid & ~i2c.rsp_nack;
  assign w_nack      = w_wait & i2c.rsp_valid & i2c.rsp_nack;
  assign w_hs        = r_cmd_valid & i2c.cmd_ready;
  assign w_last      = (r_idx == LAST_IDX);
  assign w_eoe       = (r_state == S_WAIT_D) & w_ack;
  assign w_retry_end = (({1'b0, r_retry} + 5'd1) == RETRY_MAX);
  assign w_to_gap    = (w_nack & ~w_retry_end) | (w_eoe & ~w_last);
  assign w_gap_done  = (r_state == S_GAP) & (r_gap == '0);
  assign w_load_addr = w_start_ok | w_gap_done | (w_to_gap & !HAS_GAP);
  assign w_load_reg  = (r_state == S_WAIT_A) & w_ack;
  assign w_load_data = (r_state == S_WAIT_R) & w_ack;

  // Table index looks one edge ahead so command bytes register from the
  // entry that the next state will transmit.
  assign w_idx_nxt = w_start_ok          ? '0 :
                     (w_eoe & ~w_last)   ? r_idx + 1'b1 :
                                           r_idx;

  assign o_tbl_idx     = w_idx_nxt;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_err_idx     = r_err_idx;
  assign i2c.cmd_valid = r_cmd_valid;
  assign i2c.cmd_byte  = r_cmd_byte;
  assign i2c.cmd_start = r_cmd_start;
  assign i2c.cmd_stop  = r_cmd_stop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= '0;
      r_cmd_start <= 1'b0;
      r_cmd_stop  <= 1'b0;
    end else begin
      if (w_hs)
        r_cmd_valid <= 1'b0;
      unique case (1'b1)
        w_load_addr: begin
          r_cmd_valid <= 1'b1;
          r_cmd_byte  <= {i_tbl_entry[22:16], 1'b0};
          r_cmd_start <= 1'b1;
          r_cmd_stop  <= 1'b0;
        end
        w_load_reg: begin
          r_cmd_valid <= 1'b1;
          r_cmd_byte  <= i_tbl_entry[15:8];
          r_cmd_start <= 1'b0;
          r_cmd_stop  <= 1'b0;
        end
        w_load_data: begin
          r_cmd_valid <= 1'b1;
          r_cmd_byte  <= i_tbl_entry[7:0];
          r_cmd_start <= 1'b0;
          r_cmd_stop  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_retry   <= '0;
      r_gap     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            r_retry <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: if (w_hs) r_state <= S_WAIT_A;
        S_REG:  if (w_hs) r_state <= S_WAIT_R;
        S_DATA: if (w_hs) r_state <= S_WAIT_D;
        S_WAIT_A, S_WAIT_R, S_WAIT_D: begin
          if (w_nack) begin
            r_retry <= r_retry + 1'b1;
            r_gap   <= GAP_LOAD;
            if (w_retry_end) begin
              r_error   <= 1'b1;
              r_err_idx <= r_idx;
              r_busy    <= 1'b0;
              r_state   <= S_ERROR;
            end else begin
              r_state <= HAS_GAP ? S_GAP : S_ADDR;
            end
          end else if (w_ack) begin
            if (r_state == S_WAIT_A) begin
              r_state <= S_REG;
            end else if (r_state == S_WAIT_R) begin
              r_state <= S_DATA;
            end else begin
              r_retry <= '0;
              r_gap   <= GAP_LOAD;
              if (w_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_state <= HAS_GAP ? S_GAP : S_ADDR;
              end
            end
          end
        end
        S_GAP: begin
          if (r_gap == '0)
            r_state <= S_ADDR;
          else
            r_gap <= r_gap - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// Randomized bench: acts as the I2C byte master and scoreboards the
// command stream against a table-walk reference model.
module tb_fmc_i2c_init_sequencer;
  localparam int N  = 4;
  localparam int MR = 3;
  localparam int G  = 5;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [IW-1:0] o_tbl_idx;
  logic [22:0]   i_tbl_entry;
  logic          o_busy, o_done, o_error;
  logic [IW-1:0] o_err_idx;

  fmc_i2c_init_sequencer_if bus();

  fmc_i2c_init_sequencer #(
    .NUM_ENTRIES(N),
    .MAX_RETRIES(MR),
    .GAP_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_start    (i_start),
    .o_tbl_idx  (o_tbl_idx),
    .i_tbl_entry(i_tbl_entry),
    .i2c        (bus),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error),
    .o_err_idx  (o_err_idx)
  );

  always #5 clk = ~clk;

  logic [22:0] tbl [N];
  bit          nackp [N][MR][3];

  always_comb i_tbl_entry = tbl[o_tbl_idx];

  typedef struct packed {
    logic [7:0] b;
    logic       s;
    logic       p;
    logic       nk;
  } cmd_t;

  cmd_t       exp_q[$];
  logic [7:0] obs_b[$];
  bit         exp_err;
  int         exp_eidx;
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int e, input int b);
    logic [22:0] t;
    t = tbl[e];
    if (b == 0) return {t[22:16], 1'b0};
    if (b == 1) return t[15:8];
    return t[7:0];
  endfunction

  task automatic build();
    int   a;
    bit   ok;
    cmd_t c;
    exp_q.delete();
    exp_err  = 0;
    exp_eidx = 0;
    for (int e = 0; e < N && !exp_err; e++) begin
      a  = 0;
      ok = 0;
      while (!ok && !exp_err) begin
        for (int b = 0; b < 3; b++) begin
          c.b  = fbyte(e, b);
          c.s  = (b == 0);
          c.p  = (b == 2);
          c.nk = nackp[e][a][b];
          exp_q.push_back(c);
          if (c.nk) begin
            a++;
            if (a == MR) begin
              exp_err  = 1;
              exp_eidx = e;
            end
            break;
          end
          if (b == 2) ok = 1;
        end
      end
    end
  endtask

  task automatic clear_plan();
    foreach (nackp[i, j, l]) nackp[i][j][l] = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_idx"},   o_tbl_idx, 0);
    check({tag, "_valid"}, bus.cmd_valid, 0);
    check({tag, "_byte"},  bus.cmd_byte, 0);
    check({tag, "_ss"},    {bus.cmd_start, bus.cmd_stop}, 0);
    check({tag, "_flags"}, {o_busy, o_done, o_error}, 0);
    check({tag, "_eidx"},  o_err_idx, 0);
  endtask

  task automatic run(input int stall_k, input int abort_k,
                     input int busy_start_at);
    int  k, n, pend, cur, ref_cyc, exp_dly, end_ref, stall, quiet;
    bit  pnk, prev_v, ended, abort_now, rdy;
    build();
    obs_b.delete();
    k = 0; pend = 0; cur = 0; stall = 0;
    prev_v = 0; ended = 0; abort_now = 0; pnk = 0;
    end_ref = -100;
    @(negedge clk);
    i_start = 1'b1;
    ref_cyc = 0;
    exp_dly = 1;
    for (n = 1; n < 3000 && !ended; n++) begin
      @(negedge clk);
      if (abort_now) begin
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        return;
      end
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'b0;
      i_start = (n == busy_start_at);
      check("done_err_excl", o_done & o_error, 0);
      check("busy_excl", o_busy & (o_done | o_error), 0);
      if (n == 1) check("start_flags", {o_busy, o_done, o_error}, 3'b100);
      if (!ended && (o_done || o_error)) begin
        check("end_lat", n - end_ref, 1);
        ended = 1;
      end
      if (bus.cmd_valid) begin
        if (!prev_v) check("cmd_lat", n - ref_cyc, exp_dly);
        if (k < exp_q.size()) begin
          check("cmd_byte", bus.cmd_byte, exp_q[k].b);
          check("cmd_ss", {bus.cmd_start, bus.cmd_stop},
                {exp_q[k].s, exp_q[k].p});
        end
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_nack  = pnk;
          ref_cyc = n;
          if (cur == exp_q.size() - 1) end_ref = n;
          else exp_dly = (pnk || exp_q[cur].p) ? G + 1 : 1;
        end
      end
      if (bus.cmd_valid && k == stall_k && stall < 20) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.cmd_ready = rdy;
      if (bus.cmd_valid && rdy) begin
        obs_b.push_back(bus.cmd_byte);
        if (k >= exp_q.size()) begin
          check("extra_cmd", k, exp_q.size());
        end else begin
          pnk  = exp_q[k].nk;
          cur  = k;
          pend = $urandom_range(1, 4);
          if (k == abort_k) abort_now = 1;
        end
        k++;
      end
      prev_v = bus.cmd_valid;
    end
    check("finished", ended, 1);
    check("n_cmds", k, exp_q.size());
    check("done", o_done, !exp_err);
    check("error", o_error, exp_err);
    check("busy_end", o_busy, 0);
    if (exp_err) check("err_idx", o_err_idx, exp_eidx);
    i_start = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.cmd_ready = 1'b1;
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.cmd_valid) quiet++;
    end
    check("quiet_after", quiet, 0);
  endtask

  initial begin
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_nack  = 1'b0;
    tbl[0] = {7'h3E, 8'h02, 8'h01};
    tbl[1] = {7'h70, 8'h06, 8'h10};
    tbl[2] = 23'($urandom);
    tbl[3] = 23'($urandom);
    clear_plan();
    @(negedge clk);
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    run(-1, -1, 3);
    check("first_addr", obs_b[0], 8'h7C);
    check("first_reg",  obs_b[1], 8'h02);
    check("first_data", obs_b[2], 8'h01);

    run(1, -1, -1);

    clear_plan();
    nackp[1][0][0] = 1;
    run(-1, -1, -1);

    clear_plan();
    for (int a = 0; a < MR; a++) nackp[0][a][2] = 1;
    run(-1, -1, -1);

    clear_plan();
    run(-1, -1, 7);

    for (int r = 0; r < 8; r++) begin
      for (int e = 1; e < N; e++) tbl[e] = 23'($urandom);
      foreach (nackp[i, j, l]) nackp[i][j][l] = ($urandom_range(0, 5) == 0);
      run(-1, -1, -1);
    end

    clear_plan();
    run(-1, 1, -1);
    run(-1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
